acm_line_tx: RTL and testbench



---
 rtl/acm_line_tx.sv | 214 +++++++++++++++++++++
 tb/tb_acm_line_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acm_line_tx.sv
// -----------------------------------------------------------------------------
// acm_line_tx
//
// Purpose:
//   Line-oriented byte buffer that sits between the muacm OUT pipe
//   (host->device) and the muacm IN pipe (device->host). Incoming bytes are
//   held until one of these release conditions occurs:
//     - a complete line (terminated by EOL) is stored,
//     - the FIFO is full,
//     - the input has been idle for TIMEOUT cycles.
//   The held bytes are then drained upstream. Each packet end is marked with
//   m_last, and m_flush_now is pulsed so muacm sends a short packet at once.
//
// Parameters:
//   DEPTH   - FIFO depth in bytes; power of two, 4..512
//   EOL     - line-terminator byte value
//   TIMEOUT - idle cycles before a partial line is forced out; 0 disables
//
// Ports:
//   clk          in   clock (clk_usb domain)
//   rst          in   asynchronous active-high reset
//   s_data[7:0]  in   byte from muacm out_data
//   s_valid      in   muacm out_valid
//   s_ready      out  muacm out_ready (depends only on the registered level)
//   m_data[7:0]  out  muacm in_data (head of FIFO)
//   m_last       out  muacm in_last
//   m_valid      out  muacm in_valid
//   m_ready      in   muacm in_ready
//   m_flush_now  out  muacm in_flush_now; one-cycle pulse after a packet end
// -----------------------------------------------------------------------------
module acm_line_tx #(
  parameter int          DEPTH   = 64,
  parameter logic [7:0]  EOL     = 8'h0D,
  parameter int          TIMEOUT = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_flush_now
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // The idle counter only ever needs to reach TIMEOUT-1.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] IDLE_MAX = (TIMEOUT == 0) ? '0 : IW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);

  localparam logic [0:0] ST_HOLD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] r_lines;
  logic [IW-1:0] r_idle;
  logic [0:0]    r_state;
  logic          r_force;
  logic          r_last_hold;
  logic          r_flush;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_head_eol;
  logic          w_push_eol;
  logic          w_pop_eol;
  logic          w_tmo;
  logic          w_pop_last;
  logic [LW-1:0] w_lines_next;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);

  // Back-pressure comes from the registered level only, so there is no
  // combinational path from m_ready to s_ready.
  assign s_ready = ~w_full;
  assign w_push  = s_valid & s_ready;

  // Asynchronous read of the head entry gives first-word-fall-through: a byte
  // written into an empty FIFO is at the head in the very next cycle. The head
  // entry is never overwritten while it is valid, because a write only lands
  // on the head slot when the FIFO is empty or full, and a full FIFO takes no
  // writes.
  assign m_data     = r_mem[r_rd_ptr];
  assign w_head_eol = (m_data == EOL);

  assign m_valid = (r_state == ST_DRAIN) & ~w_empty;

  // In forced mode a packet normally ends on the last stored byte. A push
  // during a stall would raise the level and drop that marker, so once m_last
  // has been offered it is held until the beat is taken.
  assign m_last = m_valid &
                  (w_head_eol | (r_force & (r_level == ONE_LVL)) | r_last_hold);

  assign w_pop      = m_valid & m_ready;
  assign w_push_eol = w_push & (s_data == EOL);
  assign w_pop_eol  = w_pop & w_head_eol;
  assign w_pop_last = w_pop & m_last;

  assign w_tmo = (TIMEOUT != 0) && (r_idle == IDLE_MAX) && !w_empty;

  assign m_flush_now = r_flush;

  always_comb begin
    w_lines_next = r_lines;
    if (w_push_eol && !w_pop_eol) begin
      w_lines_next = r_lines + ONE_LVL;
    end else if (!w_push_eol && w_pop_eol) begin
      w_lines_next = r_lines - ONE_LVL;
    end
  end

  // Storage array carries no reset; stale contents are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers, level and line count. Pointers wrap naturally because
  // DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_lines  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE_LVL;
        2'b01:   r_level <= r_level - ONE_LVL;
        default: r_level <= r_level;
      endcase
      r_lines <= w_lines_next;
    end
  end

  // Idle counter: restarts on every push or while nothing is stored, and
  // saturates at TIMEOUT-1 where it raises the timeout condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_push || w_empty) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_MAX) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  // Release state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HOLD;
      r_force <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if ((r_lines != '0) || w_full || w_tmo) begin
            r_state <= ST_DRAIN;
            // Forced mode ends the packet on the last stored byte instead of
            // waiting for an EOL that may never arrive.
            r_force <= w_full || (w_tmo && (r_lines == '0));
          end
        end
        ST_DRAIN: begin
          if (w_pop_last) begin
            // Another complete line already queued: keep draining with no
            // HOLD gap between packets.
            r_state <= (w_lines_next != '0) ? ST_DRAIN : ST_HOLD;
            r_force <= 1'b0;
          end else if (w_empty) begin
            r_state <= ST_HOLD;
            r_force <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_HOLD;
          r_force <= 1'b0;
        end
      endcase
    end
  end

  // Holds m_last across a stall, and generates the flush pulse one cycle
  // after each packet-ending pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_hold <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_last_hold <= m_last & ~m_ready;
      r_flush     <= w_pop_last;
    end
  end

endmodule

// File: tb/tb_acm_line_tx.sv
// -----------------------------------------------------------------------------
// tb_acm_line_tx
//
// Directed bench for acm_line_tx (DEPTH=8, EOL=0x0D). The main instance uses
// TIMEOUT=16; a second instance with TIMEOUT=0 shares the inputs and is
// observed only during the partial-line phase, where it must stay silent.
// Inputs are driven 1 ns after the rising edge and outputs are checked at the
// same point.
// -----------------------------------------------------------------------------
module tb_acm_line_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       m_flush_now;

  logic       b_s_ready;
  logic [7:0] b_m_data;
  logic       b_m_last;
  logic       b_m_valid;
  logic       b_m_flush_now;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  acm_line_tx #(.DEPTH(8), .EOL(8'h0D), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_flush_now (m_flush_now)
  );

  acm_line_tx #(.DEPTH(8), .EOL(8'h0D), .TIMEOUT(0)) dut_notmo (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (b_s_ready),
    .m_data      (b_m_data),
    .m_last      (b_m_last),
    .m_valid     (b_m_valid),
    .m_ready     (m_ready),
    .m_flush_now (b_m_flush_now)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_data"},  32'(m_data),  32'(d));
    check({tag, "_last"},  32'(m_last),  32'(l));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, mismatched=%0d", mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bcnt;
    logic [7:0] q[$];
    int sent;
    int rcvd;
    int budget;
    logic p_stall;
    logic p_last;
    logic p_poplast;
    logic [7:0] p_data;
    logic do_push;
    logic do_pop;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    repeat (3) step();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_flush", 32'(m_flush_now), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    step();

    // Partial line "XYZ": released only by the idle timeout.
    m_ready = 1'b1;
    send(8'h58); send(8'h59); send(8'h5A);
    cnt  = 0;
    bcnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt  += int'(m_valid);
      bcnt += int'(b_m_valid);
      step();
    end
    check("tmo_quiet", 32'(cnt), 32'd0);
    expect_beat("tmo_b0", 8'h58, 1'b0); step();
    expect_beat("tmo_b1", 8'h59, 1'b0); step();
    expect_beat("tmo_b2", 8'h5A, 1'b1);
    check("tmo_flush_pre", 32'(m_flush_now), 32'd0);
    step();
    check("tmo_end_valid", 32'(m_valid), 32'd0);
    check("tmo_flush", 32'(m_flush_now), 32'd1);
    step();
    check("tmo_flush_clr", 32'(m_flush_now), 32'd0);
    for (int i = 0; i < 30; i++) begin
      bcnt += int'(b_m_valid) + int'(b_m_last) + int'(b_m_flush_now);
      if (b_m_valid) check("notmo_data", 32'(b_m_data), 32'h0);
      step();
    end
    check("notmo_quiet", 32'(bcnt), 32'd0);
    check("notmo_s_ready", 32'(b_s_ready), 32'd1);

    // Complete line "AB\r".
    send(8'h41); send(8'h42); send(8'h0D);
    check("ab_hold", 32'(m_valid), 32'd0);
    step();
    expect_beat("ab_0", 8'h41, 1'b0); step();
    expect_beat("ab_1", 8'h42, 1'b0); step();
    expect_beat("ab_2", 8'h0D, 1'b1); step();
    check("ab_end_valid", 32'(m_valid), 32'd0);
    check("ab_flush", 32'(m_flush_now), 32'd1);
    step();
    check("ab_flush_clr", 32'(m_flush_now), 32'd0);

    // Fill all 8 entries with no EOL while the sink stalls.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("full_s_ready_pre", 32'(s_ready), 32'd1);
      send(8'(8'h10 + i));
    end
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_hold", 32'(m_valid), 32'd0);
    step();
    expect_beat("full_head", 8'h10, 1'b0);
    step(); step();
    expect_beat("full_stall", 8'h10, 1'b0);
    check("full_s_ready_stall", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    step();
    check("full_s_ready_post", 32'(s_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      expect_beat("full_beat", 8'(8'h10 + i), (i == 7));
      step();
    end
    check("full_end_valid", 32'(m_valid), 32'd0);
    check("full_flush", 32'(m_flush_now), 32'd1);
    step();

    // Two lines in one burst: back-to-back packets.
    send(8'h61); send(8'h0D); send(8'h62);
    expect_beat("burst_a", 8'h61, 1'b0);
    send(8'h0D);
    expect_beat("burst_eol0", 8'h0D, 1'b1);
    check("burst_flush0_pre", 32'(m_flush_now), 32'd0);
    step();
    expect_beat("burst_b", 8'h62, 1'b0);
    check("burst_flush0", 32'(m_flush_now), 32'd1);
    step();
    expect_beat("burst_eol1", 8'h0D, 1'b1);
    check("burst_flush_gap", 32'(m_flush_now), 32'd0);
    step();
    check("burst_end_valid", 32'(m_valid), 32'd0);
    check("burst_flush1", 32'(m_flush_now), 32'd1);
    step();
    check("burst_flush_clr", 32'(m_flush_now), 32'd0);

    // Reset in the middle of a drain with five bytes stored.
    m_ready = 1'b0;
    send(8'h70); send(8'h71); send(8'h72); send(8'h73); send(8'h0D);
    step();
    expect_beat("mid_pre", 8'h70, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_async_valid", 32'(m_valid), 32'd0);
    check("mid_async_s_ready", 32'(s_ready), 32'd1);
    step();
    rst = 1'b0;
    check("mid_valid", 32'(m_valid), 32'd0);
    check("mid_s_ready", 32'(s_ready), 32'd1);
    check("mid_flush", 32'(m_flush_now), 32'd0);
    m_ready = 1'b1;
    send(8'h51); send(8'h0D);
    check("q_hold", 32'(m_valid), 32'd0);
    step();
    expect_beat("q_0", 8'h51, 1'b0); step();
    expect_beat("q_1", 8'h0D, 1'b1); step();
    check("q_end_valid", 32'(m_valid), 32'd0);
    check("q_flush", 32'(m_flush_now), 32'd1);
    step();

    // Random traffic with 50% sink stalls, scoreboarded against a queue.
    sent      = 0;
    rcvd      = 0;
    budget    = 0;
    p_stall   = 1'b0;
    p_last    = 1'b0;
    p_poplast = 1'b0;
    p_data    = 8'h00;
    while ((sent < 1000 || q.size() != 0) && budget < 30000) begin
      budget++;
      if (p_stall) begin
        check("rnd_hold_valid", 32'(m_valid), 32'd1);
        check("rnd_hold_data", 32'(m_data), 32'(p_data));
        check("rnd_hold_last", 32'(m_last), 32'(p_last));
      end
      check("rnd_flush", 32'(m_flush_now), 32'(p_poplast));
      if (m_valid) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_valid", 32'(m_valid), 32'd0);
        end else begin
          check("rnd_data", 32'(m_data), 32'(q[0]));
        end
        if (m_data == 8'h0D) begin
          check("rnd_eol_last", 32'(m_last), 32'd1);
        end else if (m_last && !p_stall) begin
          check("rnd_forced_level", 32'(q.size()), 32'd1);
        end
      end
      s_valid = (sent < 1000) && ($urandom_range(9) < 7);
      s_data  = ($urandom_range(7) == 0) ? 8'h0D : 8'($urandom_range(255));
      m_ready = ($urandom_range(1) == 1);
      do_push   = s_valid & s_ready;
      do_pop    = m_valid & m_ready;
      p_stall   = m_valid & ~m_ready;
      p_data    = m_data;
      p_last    = m_last;
      p_poplast = do_pop & m_last;
      step();
      if (do_pop) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (do_push) begin
        q.push_back(s_data);
        sent++;
      end
    end
    s_valid = 1'b0;
    check("rnd_sent", 32'(sent), 32'd1000);
    check("rnd_rcvd", 32'(rcvd), 32'd1000);
    check("rnd_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
